// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory arbiter slice: FSM state encoding, request
// owner encoding, access size codes and a size normalisation helper.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  // Any size code other than byte or halfword is handled as a full word.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    case (size)
      SZ_B, SZ_H: norm_size = size;
      default:    norm_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three request/response channels around the arbiter:
//   if_*   : instruction fetch request (addr) and read response
//   lsu_*  : load/store request (we/addr/wdata/size) and response
//   eng_*  : request to / response from the byte-serial RAM engine
// Modports:
//   slave  : the arbiter's view (accepts IF/LSU requests, drives the engine)
//   master : the surrounding system's view (clients plus engine)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_data;

  logic              lsu_req_valid;
  logic              lsu_req_we;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [2:0]        lsu_req_size;
  logic              lsu_req_ready;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_resp_data;

  logic              eng_req_valid;
  logic              eng_req_we;
  logic [ADDR_W-1:0] eng_req_addr;
  logic [DATA_W-1:0] eng_req_wdata;
  logic [2:0]        eng_req_size;
  logic              eng_req_ready;
  logic              eng_resp_valid;
  logic [DATA_W-1:0] eng_resp_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_size,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output eng_req_valid, eng_req_we, eng_req_addr, eng_req_wdata, eng_req_size,
    input  eng_req_ready, eng_resp_valid, eng_resp_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_size,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  eng_req_valid, eng_req_we, eng_req_addr, eng_req_wdata, eng_req_size,
    output eng_req_ready, eng_resp_valid, eng_resp_rdata
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between IF and LSU.
// Ports:
//   i_idle        arbiter is in IDLE and can accept
//   i_en          global enable, already combined with reset
//   i_flush       IF redirect; an IF request is not accepted this cycle
//   i_if_valid    IF request pending
//   i_lsu_valid   LSU request pending
//   i_starve_cnt  consecutive LSU grants taken while IF was waiting
//   o_grant_if    IF wins (also drives if_req_ready)
//   o_grant_lsu   LSU wins (also drives lsu_req_ready)
// ---------------------------------------------------------------------------
module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic       i_idle,
  input  logic       i_en,
  input  logic       i_flush,
  input  logic       i_if_valid,
  input  logic       i_lsu_valid,
  input  logic [3:0] i_starve_cnt,
  output logic       o_grant_if,
  output logic       o_grant_lsu
);

  logic w_can_grant;
  logic w_if_elig;
  logic w_force_if;

  assign w_can_grant = i_idle && i_en;
  // A flushed IF request is ineligible, so LSU may still win that cycle
  // even when IF has used up its starvation budget.
  assign w_if_elig   = i_if_valid && !i_flush;
  assign w_force_if  = w_if_elig && (i_starve_cnt == 4'(STARVE_MAX));

  assign o_grant_lsu = w_can_grant && i_lsu_valid && !w_force_if;
  assign o_grant_if  = w_can_grant && w_if_elig && !o_grant_lsu;

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one byte-serial RAM engine between instruction fetch and the LSU.
// One request is latched at a time, issued to the engine with valid/ready,
// and the response is returned as a one-cycle registered pulse to its owner.
// LSU has fixed priority; IF is forced through after STARVE_MAX consecutive
// LSU grants taken while IF was waiting. flush discards an IF transaction.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   rdy        global enable; low freezes every register, forces req_ready 0
//   flush      discard the IF request/response in flight
//   bus        mem_arbiter_if.slave (IF, LSU and engine channels)
//   stat_*     grant and stall counters (only with MEM_ARB_STATS_EN)
//
// Build option: define MEM_ARB_STATS_EN to add the statistics outputs
// stat_if_grants, stat_lsu_grants and stat_stall_cycles.
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_lsu_grants,
  output logic [31:0] stat_stall_cycles
`endif
);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  arb_owner_e        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_size;
  logic [3:0]        r_starve_cnt;
  logic              r_drop;
  logic              r_if_resp_valid;
  logic [DATA_W-1:0] r_if_resp_data;
  logic              r_lsu_resp_valid;
  logic [DATA_W-1:0] r_lsu_resp_data;

  logic w_idle;
  logic w_en;
  logic w_grant_if;
  logic w_grant_lsu;
  logic w_accept;
  logic w_handshake;
  logic w_resp_done;
  logic w_if_kill;
  logic w_deliver;

  // Keep only the bytes the load asked for; upper bits read back as zero.
  function automatic logic [DATA_W-1:0] zext_resp(input logic [DATA_W-1:0] d,
                                                  input logic [2:0]        size);
    logic [DATA_W-1:0] m;
    case (size)
      SZ_B:    m = DATA_W'(8'hFF);
      SZ_H:    m = DATA_W'(16'hFFFF);
      default: m = '1;
    endcase
    return d & m;
  endfunction

  assign w_idle      = (r_state == IDLE);
  // Readies stay low during reset as well as while frozen.
  assign w_en        = rdy && !rst;
  assign w_accept    = w_grant_if || w_grant_lsu;
  assign w_handshake = (r_state == ISSUE) && bus.eng_req_ready;
  assign w_resp_done = (r_state == WAIT) && bus.eng_resp_valid;
  assign w_if_kill   = flush && (r_owner == OWN_IF);
  assign w_deliver   = w_resp_done && !r_drop && !w_if_kill;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_idle       (w_idle),
    .i_en         (w_en),
    .i_flush      (flush),
    .i_if_valid   (bus.if_req_valid),
    .i_lsu_valid  (bus.lsu_req_valid),
    .i_starve_cnt (r_starve_cnt),
    .o_grant_if   (w_grant_if),
    .o_grant_lsu  (w_grant_lsu)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (rdy) begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ISSUE;
      // A completed handshake wins over flush; the response is then dropped.
      ISSUE:   if (bus.eng_req_ready) w_next_state = WAIT;
               else if (w_if_kill)    w_next_state = IDLE;
      WAIT:    if (bus.eng_resp_valid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.eng_req_valid = (r_state == ISSUE);
    bus.if_req_ready  = w_grant_if;
    bus.lsu_req_ready = w_grant_lsu;
  end

  assign bus.eng_req_we     = r_we;
  assign bus.eng_req_addr   = r_addr;
  assign bus.eng_req_wdata  = r_wdata;
  assign bus.eng_req_size   = r_size;
  assign bus.if_resp_valid  = r_if_resp_valid;
  assign bus.if_resp_data   = r_if_resp_data;
  assign bus.lsu_resp_valid = r_lsu_resp_valid;
  assign bus.lsu_resp_data  = r_lsu_resp_data;

  // Request latch, loaded on accept (grants are already gated by rdy)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_size  <= '0;
    end else if (w_grant_lsu) begin
      r_owner <= OWN_LSU;
      r_addr  <= bus.lsu_req_addr;
      r_we    <= bus.lsu_req_we;
      r_wdata <= bus.lsu_req_wdata;
      r_size  <= norm_size(bus.lsu_req_size);
    end else if (w_grant_if) begin
      r_owner <= OWN_IF;
      r_addr  <= bus.if_req_addr;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_size  <= SZ_W;
    end
  end

  // Anti-starvation counter: counts LSU grants taken over a waiting IF
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_lsu) begin
      if (!bus.if_req_valid) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != 4'(STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else if (w_grant_if) begin
      r_starve_cnt <= '0;
    end
  end

  // drop marks an IF transaction already at the engine whose data is unwanted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else if (rdy) begin
      if (w_resp_done) begin
        r_drop <= 1'b0;
      end else if (w_if_kill && ((r_state == WAIT) || w_handshake)) begin
        r_drop <= 1'b1;
      end
    end
  end

  // Response routing: one-cycle registered pulse to the owner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_resp_valid  <= 1'b0;
      r_if_resp_data   <= '0;
      r_lsu_resp_valid <= 1'b0;
      r_lsu_resp_data  <= '0;
    end else if (rdy) begin
      r_if_resp_valid  <= w_deliver && (r_owner == OWN_IF);
      r_lsu_resp_valid <= w_deliver && (r_owner == OWN_LSU);
      if (w_deliver && (r_owner == OWN_IF)) begin
        r_if_resp_data <= bus.eng_resp_rdata;
      end
      if (w_deliver && (r_owner == OWN_LSU)) begin
        r_lsu_resp_data <= r_we ? '0 : zext_resp(bus.eng_resp_rdata, r_size);
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_if;
  logic [31:0] r_stat_lsu;
  logic [31:0] r_stat_stall;

  // Statistics counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_if    <= '0;
      r_stat_lsu   <= '0;
      r_stat_stall <= '0;
    end else if (rdy) begin
      if (w_grant_if)  r_stat_if  <= r_stat_if + 32'd1;
      if (w_grant_lsu) r_stat_lsu <= r_stat_lsu + 32'd1;
      if ((bus.if_req_valid || bus.lsu_req_valid) && !w_accept) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_if_grants    = r_stat_if;
  assign stat_lsu_grants   = r_stat_lsu;
  assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. The bench plays both clients and the RAM
// engine through the interface. Inputs change on the falling edge; outputs
// are sampled on the falling edge (or 1 time unit after it).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  int   n_vec = 0;
  int   n_bad = 0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] st_if;
  logic [31:0] st_lsu;
  logic [31:0] st_stall;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] rdata;
    logic [2:0]  exp_size;
    logic [31:0] exp_data;
  } lsu_vec_t;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_if_grants    (st_if),
    .stat_lsu_grants   (st_lsu),
    .stat_stall_cycles (st_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_we = 1'b0; bus.lsu_req_addr = 32'h0;
    bus.lsu_req_wdata = 32'h0; bus.lsu_req_size = 3'd4;
    bus.eng_req_ready = 1'b0; bus.eng_resp_valid = 1'b0; bus.eng_resp_rdata = 32'h0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.if_req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_if_ready: got %0h want 0", bus.if_req_ready); end
    n_vec++; if (bus.lsu_req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_lsu_ready: got %0h want 0", bus.lsu_req_ready); end
    n_vec++; if (bus.eng_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_eng_valid: got %0h want 0", bus.eng_req_valid); end
    n_vec++; if (bus.eng_req_addr !== 32'h0) begin n_bad++; $display("FAIL reset_eng_addr: got %0h want 0", bus.eng_req_addr); end
    n_vec++; if (bus.eng_req_size !== 3'd0) begin n_bad++; $display("FAIL reset_eng_size: got %0h want 0", bus.eng_req_size); end
    n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_if_resp: got %0h want 0", bus.if_resp_valid); end
    n_vec++; if (bus.lsu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_lsu_resp: got %0h want 0", bus.lsu_resp_valid); end
    n_vec++; if (bus.if_resp_data !== 32'h0) begin n_bad++; $display("FAIL reset_if_data: got %0h want 0", bus.if_resp_data); end
    n_vec++; if (bus.lsu_resp_data !== 32'h0) begin n_bad++; $display("FAIL reset_lsu_data: got %0h want 0", bus.lsu_resp_data); end
    bus.if_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h100; bus.eng_req_ready = 1'b1;
    #1;
    n_vec++; if (bus.if_req_ready !== 1'b1) begin n_bad++; $display("FAIL ifrd_ready: got %0h want 1", bus.if_req_ready); end
    n_vec++; if (bus.lsu_req_ready !== 1'b0) begin n_bad++; $display("FAIL ifrd_lsu_ready: got %0h want 0", bus.lsu_req_ready); end
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    n_vec++; if (bus.eng_req_valid !== 1'b1) begin n_bad++; $display("FAIL ifrd_eng_valid: got %0h want 1", bus.eng_req_valid); end
    n_vec++; if (bus.eng_req_addr !== 32'h100) begin n_bad++; $display("FAIL ifrd_eng_addr: got %0h want 100", bus.eng_req_addr); end
    n_vec++; if (bus.eng_req_we !== 1'b0) begin n_bad++; $display("FAIL ifrd_eng_we: got %0h want 0", bus.eng_req_we); end
    n_vec++; if (bus.eng_req_size !== 3'd4) begin n_bad++; $display("FAIL ifrd_eng_size: got %0h want 4", bus.eng_req_size); end
    @(negedge clk);
    n_vec++; if (bus.eng_req_valid !== 1'b0) begin n_bad++; $display("FAIL ifrd_eng_valid_drop: got %0h want 0", bus.eng_req_valid); end
    repeat (3) @(negedge clk);
    bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.eng_resp_valid = 1'b0;
    n_vec++; if (bus.if_resp_valid !== 1'b1) begin n_bad++; $display("FAIL ifrd_resp_valid: got %0h want 1", bus.if_resp_valid); end
    n_vec++; if (bus.if_resp_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ifrd_resp_data: got %0h want deadbeef", bus.if_resp_data); end
    n_vec++; if (bus.lsu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL ifrd_lsu_resp: got %0h want 0", bus.lsu_resp_valid); end
    bus.if_req_valid = 1'b1;
    #1;
    n_vec++; if (bus.if_req_ready !== 1'b1) begin n_bad++; $display("FAIL ifrd_next_accept: got %0h want 1", bus.if_req_ready); end
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL ifrd_resp_pulse: got %0h want 0", bus.if_resp_valid); end
  endtask

  task automatic test_contention();
    logic [5:0] seq_if;
    logic [5:0] exp_if;
    int         got;
    int         if_pulses;
    int         lsu_pulses;
    int         both;
    exp_if = 6'b010000;  // grant index 4 (the 5th) goes to IF
    seq_if = '0; got = 0; if_pulses = 0; lsu_pulses = 0; both = 0;
    bus.eng_req_ready = 1'b1; bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = 32'hA5A5A5A5;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h400;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_we = 1'b0; bus.lsu_req_addr = 32'h800;
    bus.lsu_req_wdata = 32'h0; bus.lsu_req_size = 3'd4;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      #1;
      if (bus.if_resp_valid === 1'b1) if_pulses++;
      if (bus.lsu_resp_valid === 1'b1) lsu_pulses++;
      if (bus.if_req_ready === 1'b1 && bus.lsu_req_ready === 1'b1) both++;
      if (bus.if_req_ready === 1'b1 || bus.lsu_req_ready === 1'b1) begin
        seq_if[got] = bus.if_req_ready;
        got++;
        if (got == 6) begin
          bus.if_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.if_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    n_vec++; if (got !== 6) begin n_bad++; $display("FAIL cont_grant_count: got %0d want 6 within budget", got); end
    for (int k = 0; k < 6; k++) begin
      n_vec++; if (seq_if[k] !== exp_if[k]) begin n_bad++; $display("FAIL cont_grant%0d_is_if: got %0h want %0h", k, seq_if[k], exp_if[k]); end
    end
    n_vec++; if (both !== 0) begin n_bad++; $display("FAIL cont_dual_ready: got %0d cycles want 0", both); end
    n_vec++; if (if_pulses !== 1) begin n_bad++; $display("FAIL cont_if_resps: got %0d want 1", if_pulses); end
    n_vec++; if (lsu_pulses !== 4) begin n_bad++; $display("FAIL cont_lsu_resps: got %0d want 4", lsu_pulses); end
    bus.eng_resp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsu_access();
    lsu_vec_t v [5];
    v[0] = '{1'b0, 32'h200, 32'h11111111, 3'd1, 32'h12345678, 3'd1, 32'h00000078};
    v[1] = '{1'b0, 32'h204, 32'h22222222, 3'd2, 32'h12345678, 3'd2, 32'h00005678};
    v[2] = '{1'b0, 32'h208, 32'h33333333, 3'd3, 32'h12345678, 3'd4, 32'h12345678};
    v[3] = '{1'b1, 32'h20C, 32'hCAFEF00D, 3'd4, 32'hFFFFFFFF, 3'd4, 32'h00000000};
    v[4] = '{1'b0, 32'h210, 32'h44444444, 3'd7, 32'h87654321, 3'd4, 32'h87654321};
    bus.eng_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.lsu_req_valid = 1'b1; bus.lsu_req_we = v[i].we; bus.lsu_req_addr = v[i].addr;
      bus.lsu_req_wdata = v[i].wdata; bus.lsu_req_size = v[i].size;
      #1;
      n_vec++; if (bus.lsu_req_ready !== 1'b1) begin n_bad++; $display("FAIL lsu%0d_ready: got %0h want 1", i, bus.lsu_req_ready); end
      @(negedge clk);
      bus.lsu_req_valid = 1'b0;
      n_vec++; if (bus.eng_req_valid !== 1'b1) begin n_bad++; $display("FAIL lsu%0d_eng_valid: got %0h want 1", i, bus.eng_req_valid); end
      n_vec++; if (bus.eng_req_addr !== v[i].addr) begin n_bad++; $display("FAIL lsu%0d_eng_addr: got %0h want %0h", i, bus.eng_req_addr, v[i].addr); end
      n_vec++; if (bus.eng_req_we !== v[i].we) begin n_bad++; $display("FAIL lsu%0d_eng_we: got %0h want %0h", i, bus.eng_req_we, v[i].we); end
      n_vec++; if (bus.eng_req_wdata !== v[i].wdata) begin n_bad++; $display("FAIL lsu%0d_eng_wdata: got %0h want %0h", i, bus.eng_req_wdata, v[i].wdata); end
      n_vec++; if (bus.eng_req_size !== v[i].exp_size) begin n_bad++; $display("FAIL lsu%0d_eng_size: got %0h want %0h", i, bus.eng_req_size, v[i].exp_size); end
      @(negedge clk);
      bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = v[i].rdata;
      @(negedge clk);
      bus.eng_resp_valid = 1'b0;
      n_vec++; if (bus.lsu_resp_valid !== 1'b1) begin n_bad++; $display("FAIL lsu%0d_resp_valid: got %0h want 1", i, bus.lsu_resp_valid); end
      n_vec++; if (bus.lsu_resp_data !== v[i].exp_data) begin n_bad++; $display("FAIL lsu%0d_resp_data: got %0h want %0h", i, bus.lsu_resp_data, v[i].exp_data); end
      n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL lsu%0d_if_resp: got %0h want 0", i, bus.if_resp_valid); end
    end
  endtask

  task automatic test_flush_wait();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h300; bus.eng_req_ready = 1'b1;
    #1;
    n_vec++; if (bus.if_req_ready !== 1'b1) begin n_bad++; $display("FAIL fw_ready: got %0h want 1", bus.if_req_ready); end
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = 32'h11111111;
    @(negedge clk);
    bus.eng_resp_valid = 1'b0;
    n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fw_suppressed: got %0h want 0", bus.if_resp_valid); end
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h304;
    #1;
    n_vec++; if (bus.if_req_ready !== 1'b1) begin n_bad++; $display("FAIL fw_reaccept: got %0h want 1", bus.if_req_ready); end
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fw_suppressed_late: got %0h want 0", bus.if_resp_valid); end
    n_vec++; if (bus.eng_req_addr !== 32'h304) begin n_bad++; $display("FAIL fw_new_addr: got %0h want 304", bus.eng_req_addr); end
    @(negedge clk);
    bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = 32'h0BADCAFE;
    @(negedge clk);
    bus.eng_resp_valid = 1'b0;
    n_vec++; if (bus.if_resp_valid !== 1'b1) begin n_bad++; $display("FAIL fw_new_resp: got %0h want 1", bus.if_resp_valid); end
    n_vec++; if (bus.if_resp_data !== 32'h0BADCAFE) begin n_bad++; $display("FAIL fw_new_data: got %0h want badcafe", bus.if_resp_data); end
  endtask

  task automatic test_flush_issue();
    bus.eng_req_ready = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h500;
    #1;
    n_vec++; if (bus.if_req_ready !== 1'b1) begin n_bad++; $display("FAIL fi_ready: got %0h want 1", bus.if_req_ready); end
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    n_vec++; if (bus.eng_req_valid !== 1'b1) begin n_bad++; $display("FAIL fi_issue: got %0h want 1", bus.eng_req_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++; if (bus.eng_req_valid !== 1'b0) begin n_bad++; $display("FAIL fi_valid_drop: got %0h want 0", bus.eng_req_valid); end
    // a stray engine response while idle must not surface anywhere
    bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = 32'h99999999;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (bus.if_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fi_no_resp%0d: got if=%0h lsu=%0h want 0/0", c, bus.if_resp_valid, bus.lsu_resp_valid); end
    end
    bus.eng_resp_valid = 1'b0;
    bus.if_req_valid = 1'b1; flush = 1'b1;
    #1;
    n_vec++; if (bus.if_req_ready !== 1'b0) begin n_bad++; $display("FAIL fi_idle_flush_block: got %0h want 0", bus.if_req_ready); end
    flush = 1'b0;
    #1;
    n_vec++; if (bus.if_req_ready !== 1'b1) begin n_bad++; $display("FAIL fi_idle_unblock: got %0h want 1", bus.if_req_ready); end
    bus.if_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush_lsu();
    bus.eng_req_ready = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_we = 1'b0; bus.lsu_req_addr = 32'h600;
    bus.lsu_req_wdata = 32'h0; bus.lsu_req_size = 3'd2;
    flush = 1'b1;
    #1;
    n_vec++; if (bus.lsu_req_ready !== 1'b1) begin n_bad++; $display("FAIL fl_ready: got %0h want 1", bus.lsu_req_ready); end
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.eng_req_valid !== 1'b1) begin n_bad++; $display("FAIL fl_issue_kept: got %0h want 1", bus.eng_req_valid); end
    bus.eng_req_ready = 1'b1;
    @(negedge clk);
    bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = 32'hAABBCCDD;
    @(negedge clk);
    bus.eng_resp_valid = 1'b0; flush = 1'b0;
    n_vec++; if (bus.lsu_resp_valid !== 1'b1) begin n_bad++; $display("FAIL fl_resp_valid: got %0h want 1", bus.lsu_resp_valid); end
    n_vec++; if (bus.lsu_resp_data !== 32'h0000CCDD) begin n_bad++; $display("FAIL fl_resp_data: got %0h want ccdd", bus.lsu_resp_data); end
  endtask

  task automatic test_rdy_freeze();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h700; bus.eng_req_ready = 1'b1;
    rdy = 1'b0;
    #1;
    n_vec++; if (bus.if_req_ready !== 1'b0) begin n_bad++; $display("FAIL rz_ready_forced: got %0h want 0", bus.if_req_ready); end
    @(negedge clk);
    n_vec++; if (bus.eng_req_valid !== 1'b0) begin n_bad++; $display("FAIL rz_no_accept: got %0h want 0", bus.eng_req_valid); end
    rdy = 1'b1;
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    n_vec++; if (bus.eng_req_valid !== 1'b1) begin n_bad++; $display("FAIL rz_issue: got %0h want 1", bus.eng_req_valid); end
    @(negedge clk);
    rdy = 1'b0; bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = 32'h13572468;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_size = 3'd4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rz_frozen_resp%0d: got %0h want 0", c, bus.if_resp_valid); end
      n_vec++; if (bus.lsu_req_ready !== 1'b0) begin n_bad++; $display("FAIL rz_frozen_ready%0d: got %0h want 0", c, bus.lsu_req_ready); end
    end
    bus.lsu_req_valid = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    bus.eng_resp_valid = 1'b0;
    n_vec++; if (bus.if_resp_valid !== 1'b1) begin n_bad++; $display("FAIL rz_resp_after: got %0h want 1", bus.if_resp_valid); end
    n_vec++; if (bus.if_resp_data !== 32'h13572468) begin n_bad++; $display("FAIL rz_resp_data: got %0h want 13572468", bus.if_resp_data); end
    rdy = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.if_resp_valid !== 1'b1) begin n_bad++; $display("FAIL rz_pulse_hold: got %0h want 1", bus.if_resp_valid); end
    rdy = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rz_pulse_end: got %0h want 0", bus.if_resp_valid); end
  endtask

  task automatic test_reset_mid();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h800; bus.eng_req_ready = 1'b1;
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus.eng_resp_valid = 1'b1; bus.eng_resp_rdata = 32'h55555555;
    @(negedge clk);
    rst = 1'b0; bus.eng_resp_valid = 1'b0;
    n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_resp: got %0h want 0", bus.if_resp_valid); end
    n_vec++; if (bus.if_resp_data !== 32'h0) begin n_bad++; $display("FAIL rm_data_clr: got %0h want 0", bus.if_resp_data); end
    n_vec++; if (bus.eng_req_addr !== 32'h0) begin n_bad++; $display("FAIL rm_addr_clr: got %0h want 0", bus.eng_req_addr); end
    @(negedge clk);
    n_vec++; if (bus.if_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_resp_late: got %0h want 0", bus.if_resp_valid); end
    n_vec++; if (bus.eng_req_valid !== 1'b0) begin n_bad++; $display("FAIL rm_idle: got %0h want 0", bus.eng_req_valid); end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_contention();
    test_lsu_access();
    test_flush_wait();
    test_flush_issue();
    test_flush_lsu();
    test_rdy_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single byte-serial RAM engine between instruction fetch (IF) and load/store unit (LSU).
- Latches one request at a time, issues it to the engine over a valid/ready handshake, and routes the response back to its owner.
- Fixed LSU priority with an IF anti-starvation counter.
- Supports IF flush on branch redirect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive LSU grants allowed while IF is waiting; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  discard the IF request/response in flight.
- if_req_valid  in  1; if_req_addr  in  ADDR_W; if_req_ready  out  1.
- if_resp_valid  out  1; if_resp_data  out  DATA_W.
- lsu_req_valid  in  1; lsu_req_we  in  1; lsu_req_addr  in  ADDR_W.
- lsu_req_wdata  in  DATA_W; lsu_req_size  in  3 (bytes: 1, 2, 4); lsu_req_ready  out  1.
- lsu_resp_valid  out  1; lsu_resp_data  out  DATA_W.
- eng_req_valid  out  1; eng_req_we  out  1; eng_req_addr  out  ADDR_W.
- eng_req_wdata  out  DATA_W; eng_req_size  out  3; eng_req_ready  in  1.
- eng_resp_valid  in  1; eng_resp_rdata  in  DATA_W.

Behaviour:
- Reset: state=IDLE, starve_cnt=0, drop=0, owner=IF. All outputs 0, including eng_req_* and resp data.
- rdy low: no register updates. if_req_ready and lsu_req_ready are forced 0. Registered outputs hold their value; consumers qualify them with rdy.
- States: IDLE, ISSUE, WAIT.
- IDLE winner selection:
  - LSU wins if lsu_req_valid, unless if_req_valid and starve_cnt==STARVE_MAX; then IF wins.
  - Otherwise IF wins if if_req_valid.
- Ready outputs: only the winner's req_ready is 1 (combinational, IDLE only).
- On accept: latch addr/we/wdata/size/owner, then go to ISSUE.
- IF requests: we=0, size=4.
- LSU size values other than 1, 2, 4 are treated as 4.
- flush in IDLE blocks IF accept that cycle.
- starve_cnt on accept:
  - LSU grant with if_req_valid=1: increment, saturating at STARVE_MAX.
  - LSU grant with if_req_valid=0: clear.
  - IF grant: clear.
- ISSUE: eng_req_valid=1 with the latched fields.
  - On eng_req_ready go to WAIT.
  - flush while owner=IF and the handshake has not occurred: drop eng_req_valid next cycle, return to IDLE, no response.
- WAIT: on eng_resp_valid, go to IDLE next cycle.
  - The owner's resp_valid pulses 1 cycle, registered, at R+1.
  - lsu_resp_data is zero-extended per size (size 1 keeps [7:0], size 2 keeps [15:0]).
  - Writes also pulse lsu_resp_valid, with data 0.
  - flush while owner=IF sets drop; the response is then suppressed and drop clears.
  - flush coincident with eng_resp_valid also suppresses.
- Latency:
  - Accept at T gives eng_req_valid at T+1.
  - Engine response at R gives owner resp_valid at R+1.
  - The next accept is possible at R+1.
- Only one transaction is outstanding; eng_resp_valid outside WAIT is ignored.
- flush never affects LSU transactions.
- Reset mid-transaction: abandon immediately with no response. The engine is reset by the same rst.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds outputs stat_if_grants (32), stat_lsu_grants (32) and stat_stall_cycles (32).
  - Grant counters count accepts.
  - stat_stall_cycles counts cycles with any req_valid=1 and no accept.
  - All three wrap at 2^32, reset to 0, and freeze with rdy.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - owner encoding (OWN_IF=0, OWN_LSU=1);
  - size codes (SZ_B=1, SZ_H=2, SZ_W=4).
- Natural sub-module: mem_arb_pick, the combinational winner/ready selection from valids, starve_cnt and flush.

Test Plan:
- Single IF read: if_req_valid at T with addr 0x100, engine ready immediately, eng_resp_rdata 0xDEADBEEF at T+5 -> if_resp_valid=1 at T+6 with data 0xDEADBEEF.
- Contention, STARVE_MAX=4: both valids held high -> LSU granted 4 times, 5th grant goes to IF, starve_cnt returns to 0.
- LSU byte load, size=1: engine returns 0x12345678 -> lsu_resp_data=0x00000078. Same with size=2 -> 0x00005678.
- Flush in WAIT: IF read in flight, flush pulses 1 cycle -> no if_resp_valid on completion, then a new IF accept succeeds.
- Flush in ISSUE with eng_req_ready=0: eng_req_valid drops the next cycle, state returns to IDLE, and no response ever occurs.
- rdy=0 for 3 cycles mid-WAIT with eng_resp_valid held -> no state change and req_ready=0; the response is delivered after rdy returns.
